// File: rtl/alu_pipe_param.sv
// alu_pipe_param -- parametrised, handshaked ALU.
//   Sits between the operand/command sequencer and result writeback.
//   Single-cycle ops issue one edge after acceptance; multiplies take a
//   second edge in MUL2.  Operands may arrive on different cycles: the
//   first one is captured together with CMD/MODE/CIN, and the missing
//   one is awaited for at most TIMEOUT cycles before an error is issued.
//
// Optional feature macro: ALU_SAT_EN (saturating add/sub/signed add/sub).
//
// Parameters:
//   OP_WIDTH  operand width W (power of two, >= 4)
//   TIMEOUT   cycles to wait for a missing operand (>= 1)
// Ports:
//   CLK        in   clock, rising edge
//   RST        in   synchronous active-high reset
//   CE         in   clock enable, 0 freezes the block (RES_VALID drops)
//   MODE       in   1 = arithmetic, 0 = logical
//   CMD        in   [3:0] operation code
//   OPA, OPB   in   [W-1:0] operands
//   CIN        in   carry/borrow in
//   INP_VALID  in   [1:0] bit0 = OPA valid, bit1 = OPB valid
//   RES        out  [2W-1:0] result
//   COUT, OFLOW, G, E, L, ERR  out  result flags
//   RES_VALID  out  one-cycle result strobe
//   BUSY       out  1 while collecting an operand or multiplying
module alu_pipe_param #(
   parameter int OP_WIDTH = 8,
   parameter int TIMEOUT  = 16
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic                    CE,
   input  logic                    MODE,
   input  logic [3:0]              CMD,
   input  logic [OP_WIDTH-1:0]     OPA,
   input  logic [OP_WIDTH-1:0]     OPB,
   input  logic                    CIN,
   input  logic [1:0]              INP_VALID,
   output logic [2*OP_WIDTH-1:0]   RES,
   output logic                    COUT,
   output logic                    OFLOW,
   output logic                    G,
   output logic                    E,
   output logic                    L,
   output logic                    ERR,
   output logic                    RES_VALID,
   output logic                    BUSY
);

   localparam int W     = OP_WIDTH;
   localparam int RW    = 2 * OP_WIDTH;
   localparam int SH_W  = $clog2(OP_WIDTH);
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE = 2'd0, COLLECT = 2'd1, MUL2 = 2'd2} state_t;

   // Operands required by an op: bit0 = A, bit1 = B.  Unlisted codes need
   // nothing, so any valid input issues their error result immediately.
   function automatic logic [1:0] need_ops(input logic mode, input logic [3:0] cmd);
      logic [1:0] n;
      n = 2'b00;
      if (mode) begin
         case (cmd)
            4'd4, 4'd5: n = 2'b01;
            4'd6, 4'd7: n = 2'b10;
            4'd0, 4'd1, 4'd2, 4'd3, 4'd8, 4'd9, 4'd10, 4'd11, 4'd12: n = 2'b11;
            default: n = 2'b00;
         endcase
      end else begin
         case (cmd)
            4'd6, 4'd8, 4'd9:   n = 2'b01;
            4'd7, 4'd10, 4'd11: n = 2'b10;
            4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd12, 4'd13: n = 2'b11;
            default: n = 2'b00;
         endcase
      end
      return n;
   endfunction

   function automatic logic is_mul(input logic mode, input logic [3:0] cmd);
      return mode && ((cmd == 4'd9) || (cmd == 4'd10));
   endfunction

   // Full ALU evaluation; returns {ERR, L, E, G, OFLOW, COUT, RES}.
   function automatic logic [RW+5:0] alu_exec(input logic mode, input logic [3:0] cmd,
                                              input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic cin);
      logic [RW-1:0]  res;
      logic           cout, oflow, g, e, l, err;
      logic [W:0]     wide;
      logic [RW-1:0]  ma, mb;
      logic [2*W-1:0] dbl;
      logic           hi_set;
      res = {RW{1'b0}};
      cout = 1'b0; oflow = 1'b0; g = 1'b0; e = 1'b0; l = 1'b0; err = 1'b0;
      wide = {(W+1){1'b0}};
      ma = {RW{1'b0}};
      mb = {RW{1'b0}};
      dbl = {(2*W){1'b0}};
      hi_set = ((b >> SH_W) != {W{1'b0}});
      if (mode) begin
         case (cmd)
            4'd0, 4'd2: begin
               wide = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, (cmd == 4'd2) ? cin : 1'b0};
               cout = wide[W];
`ifdef ALU_SAT_EN
               res = cout ? {{W{1'b0}}, {W{1'b1}}} : {{(W-1){1'b0}}, wide};
`else
               res = {{(W-1){1'b0}}, wide};
`endif
            end
            4'd1, 4'd3: begin
               // Bit W of the W+1-bit difference is the borrow.
               wide  = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, (cmd == 4'd3) ? cin : 1'b0};
               oflow = wide[W];
`ifdef ALU_SAT_EN
               res = oflow ? {RW{1'b0}} : {{(W-1){1'b0}}, wide};
`else
               res = {{(W-1){1'b0}}, wide};
`endif
            end
            4'd4, 4'd6: begin
               wide  = {1'b0, (cmd == 4'd4) ? a : b} + {{W{1'b0}}, 1'b1};
               oflow = wide[W];
               res   = {{(W-1){1'b0}}, wide};
            end
            4'd5, 4'd7: begin
               // Decrement of zero is flagged and clamps at zero.
               wide = {1'b0, (cmd == 4'd5) ? a : b};
               if (wide == {(W+1){1'b0}}) begin
                  oflow = 1'b1;
               end else begin
                  res = {{(W-1){1'b0}}, wide - {{W{1'b0}}, 1'b1}};
               end
            end
            4'd8: begin
               g = (a > b);
               e = (a == b);
               l = (a < b);
            end
            4'd9: begin
               // Only A = B = all-ones exceeds 2W bits; RES is 2W wide.
               ma  = {{W{1'b0}}, a} + {{(RW-1){1'b0}}, 1'b1};
               mb  = {{W{1'b0}}, b} + {{(RW-1){1'b0}}, 1'b1};
               res = ma * mb;
            end
            4'd10: begin
               ma  = {{(W-1){1'b0}}, a, 1'b0};
               mb  = {{W{1'b0}}, b};
               res = ma * mb;
            end
            4'd11, 4'd12: begin
               wide  = (cmd == 4'd11) ? ({a[W-1], a} + {b[W-1], b})
                                      : ({a[W-1], a} - {b[W-1], b});
               oflow = wide[W] ^ wide[W-1];
               g     = ($signed(a) >  $signed(b));
               e     = (a == b);
               l     = ($signed(a) <  $signed(b));
               res   = {{(W-1){wide[W]}}, wide};
`ifdef ALU_SAT_EN
               // True sign is bit W: negative overflow clamps to min.
               if (oflow) begin
                  res = wide[W] ? {{(W+1){1'b1}}, {(W-1){1'b0}}}
                                : {{(W+1){1'b0}}, {(W-1){1'b1}}};
               end
`endif
            end
            default: err = 1'b1;
         endcase
      end else begin
         case (cmd)
            4'd0:  res = {{W{1'b0}}, a & b};
            4'd1:  res = {{W{1'b0}}, ~(a & b)};
            4'd2:  res = {{W{1'b0}}, a | b};
            4'd3:  res = {{W{1'b0}}, ~(a | b)};
            4'd4:  res = {{W{1'b0}}, a ^ b};
            4'd5:  res = {{W{1'b0}}, ~(a ^ b)};
            4'd6:  res = {{W{1'b0}}, ~a};
            4'd7:  res = {{W{1'b0}}, ~b};
            4'd8:  res = {{W{1'b0}}, 1'b0, a[W-1:1]};
            4'd9:  res = {{W{1'b0}}, a[W-2:0], 1'b0};
            4'd10: res = {{W{1'b0}}, 1'b0, b[W-1:1]};
            4'd11: res = {{W{1'b0}}, b[W-2:0], 1'b0};
            4'd12, 4'd13: begin
               // Rotate via a doubled copy of A; out-of-range amount is an error.
               if (hi_set) begin
                  err = 1'b1;
               end else if (cmd == 4'd12) begin
                  dbl = {a, a} << b[SH_W-1:0];
                  res = {{W{1'b0}}, dbl[2*W-1:W]};
               end else begin
                  dbl = {a, a} >> b[SH_W-1:0];
                  res = {{W{1'b0}}, dbl[W-1:0]};
               end
            end
            default: err = 1'b1;
         endcase
      end
      return {err, l, e, g, oflow, cout, res};
   endfunction

   state_t           state_r;
   logic [CNT_W-1:0] cnt_r;
   logic [W-1:0]     op_a_r, op_b_r;
   logic [3:0]       cmd_r;
   logic             mode_r, cin_r;
   logic [1:0]       miss_r;

   logic [1:0]       need_s;
   logic             x_mode_s, x_cin_s;
   logic [3:0]       x_cmd_s;
   logic [W-1:0]     x_a_s, x_b_s;
   logic [RW+5:0]    exec_s;

   assign need_s = need_ops(MODE, CMD);

   // Select the operand/command source the ALU evaluates this cycle.
   always_comb begin
      x_mode_s = MODE;
      x_cmd_s  = CMD;
      x_a_s    = OPA;
      x_b_s    = OPB;
      x_cin_s  = CIN;
      case (state_r)
         COLLECT: begin
            x_mode_s = mode_r;
            x_cmd_s  = cmd_r;
            x_a_s    = miss_r[0] ? OPA : op_a_r;
            x_b_s    = miss_r[1] ? OPB : op_b_r;
            x_cin_s  = cin_r;
         end
         MUL2: begin
            x_mode_s = mode_r;
            x_cmd_s  = cmd_r;
            x_a_s    = op_a_r;
            x_b_s    = op_b_r;
            x_cin_s  = cin_r;
         end
         default: begin
            x_mode_s = MODE;
            x_cmd_s  = CMD;
         end
      endcase
   end

   assign exec_s = alu_exec(x_mode_s, x_cmd_s, x_a_s, x_b_s, x_cin_s);

   // Control FSM, operand capture and registered result outputs.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_r   <= IDLE;
         cnt_r     <= {CNT_W{1'b0}};
         op_a_r    <= {W{1'b0}};
         op_b_r    <= {W{1'b0}};
         cmd_r     <= 4'd0;
         mode_r    <= 1'b0;
         cin_r     <= 1'b0;
         miss_r    <= 2'b00;
         {ERR, L, E, G, OFLOW, COUT, RES} <= {(RW+6){1'b0}};
         RES_VALID <= 1'b0;
         BUSY      <= 1'b0;
      end else if (!CE) begin
         RES_VALID <= 1'b0;
      end else begin
         RES_VALID <= 1'b0;
         case (state_r)
            IDLE: begin
               if (INP_VALID != 2'b00) begin
                  cmd_r  <= CMD;
                  mode_r <= MODE;
                  cin_r  <= CIN;
                  op_a_r <= OPA;
                  op_b_r <= OPB;
                  if ((need_s & ~INP_VALID) == 2'b00) begin
                     if (is_mul(MODE, CMD)) begin
                        state_r <= MUL2;
                        BUSY    <= 1'b1;
                     end else begin
                        {ERR, L, E, G, OFLOW, COUT, RES} <= exec_s;
                        RES_VALID <= 1'b1;
                     end
                  end else begin
                     miss_r  <= need_s & ~INP_VALID;
                     cnt_r   <= {CNT_W{1'b0}};
                     state_r <= COLLECT;
                     BUSY    <= 1'b1;
                  end
               end
            end
            COLLECT: begin
               if ((INP_VALID & miss_r) != 2'b00) begin
                  if (miss_r[0]) op_a_r <= OPA;
                  if (miss_r[1]) op_b_r <= OPB;
                  if (is_mul(mode_r, cmd_r)) begin
                     state_r <= MUL2;
                  end else begin
                     {ERR, L, E, G, OFLOW, COUT, RES} <= exec_s;
                     RES_VALID <= 1'b1;
                     state_r   <= IDLE;
                     BUSY      <= 1'b0;
                  end
               end else if (cnt_r == CNT_W'(TIMEOUT - 1)) begin
                  {ERR, L, E, G, OFLOW, COUT, RES} <= {1'b1, 5'b00000, {RW{1'b0}}};
                  RES_VALID <= 1'b1;
                  state_r   <= IDLE;
                  BUSY      <= 1'b0;
               end else begin
                  cnt_r <= cnt_r + CNT_W'(1);
               end
            end
            MUL2: begin
               {ERR, L, E, G, OFLOW, COUT, RES} <= exec_s;
               RES_VALID <= 1'b1;
               state_r   <= IDLE;
               BUSY      <= 1'b0;
            end
            default: begin
               state_r <= IDLE;
               BUSY    <= 1'b0;
            end
         endcase
      end
   end

endmodule
